// File: rtl/bpd_update_pkg.sv
// ----------------------------------------------------------------------------
// bpd_update_pkg
// Shared types and constants for the branch-predictor update path.
//   bpd_update_t  : packed update packet (BPD_UPDATE_W bits, MSB first as listed)
//   BPD_UPDATE_W  : packet width in bits
//   FETCH_WIDTH   : instructions per fetch packet (sizes btb_mispredicts/br_mask)
// ----------------------------------------------------------------------------
package bpd_update_pkg;

  localparam int BPD_UPDATE_W = 412;
  localparam int FETCH_WIDTH  = 8;

  typedef struct packed {
    logic                   is_mispredict_update;
    logic                   is_repair_update;
    logic [FETCH_WIDTH-1:0] btb_mispredicts;
    logic [39:0]            pc;
    logic [FETCH_WIDTH-1:0] br_mask;
    logic                   cfi_idx_valid;
    logic [2:0]             cfi_idx_bits;
    logic                   cfi_taken;
    logic                   cfi_mispredicted;
    logic                   cfi_is_br;
    logic                   cfi_is_jal;
    logic [63:0]            ghist_old_history;
    logic                   ghist_new_saw_branch_not_taken;
    logic                   ghist_new_saw_branch_taken;
    logic [39:0]            target;
    logic [119:0]           meta_0;
    logic [119:0]           meta_1;
  } bpd_update_t;

endpackage

// File: rtl/bpd_starve_counter.sv
// ----------------------------------------------------------------------------
// bpd_starve_counter
// Counts consecutive cycles in which the queue head is offered but not taken,
// and flags starvation once that run reaches STARVE_LIMIT.
//   clock, reset : clock and asynchronous active-high reset
//   flush        : synchronous clear
//   deq_valid    : head entry offered to the arbiter
//   deq_ready    : arbiter accepts the head entry
//   starve       : registered, high while the blocked run is >= STARVE_LIMIT
// ----------------------------------------------------------------------------
module bpd_starve_counter #(
  parameter int STARVE_LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic deq_valid,
  input  logic deq_ready,
  output logic starve
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             starve_r;

  // Next blocked-run length: cleared by flush, empty or a delivery, saturates at the limit.
  always_comb begin
    cnt_next_s = cnt_r;
    if (flush || !deq_valid || deq_ready) begin
      cnt_next_s = '0;
    end else if (cnt_r >= LIMIT_C) begin
      cnt_next_s = cnt_r;
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // Counter and flag registers; the flag is built from the next count so it
  // rises right after the limit-th blocked cycle and falls right after a delivery.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r    <= '0;
      starve_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_next_s;
      starve_r <= (cnt_next_s >= LIMIT_C);
    end
  end

  assign starve = starve_r;

endmodule

// File: rtl/bpd_commit_update_queue.sv
// ----------------------------------------------------------------------------
// bpd_commit_update_queue
// FIFO holding commit-time predictor update packets in front of the low-priority
// input of the predictor-update arbiter, with starvation reporting.
// Optional build macro: BPD_UPDQ_BYPASS_EN (empty-queue combinational bypass).
//   clock, reset          : clock and asynchronous active-high reset
//   flush                 : synchronous discard of all entries
//   enq_valid/ready/bits  : upstream (FTQ commit) packet handshake
//   deq_valid/ready/bits  : downstream (arbiter input 1) handshake, head entry
//   count                 : current occupancy
//   starve                : head blocked for at least STARVE_LIMIT cycles
// ----------------------------------------------------------------------------
module bpd_commit_update_queue
  import bpd_update_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [BPD_UPDATE_W-1:0] enq_bits,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [BPD_UPDATE_W-1:0] deq_bits,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    starve
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [BPD_UPDATE_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]        head_r;
  logic [PTR_W-1:0]        tail_r;
  logic [CNT_W-1:0]        count_r;

  logic enq_fire_s;
  logic deq_fire_s;
  logic bypass_take_s;
  logic push_s;
  logic pop_s;

  // Handshake and head data; full/empty come from the occupancy count only.
  always_comb begin
    enq_ready     = (count_r != FULL_C);
    bypass_take_s = 1'b0;
`ifdef BPD_UPDQ_BYPASS_EN
    if (count_r == '0) begin
      deq_valid     = enq_valid;
      deq_bits      = enq_bits;
      bypass_take_s = enq_valid && deq_ready;
    end else begin
      deq_valid     = 1'b1;
      deq_bits      = mem_r[head_r];
    end
`else
    deq_valid = (count_r != '0);
    deq_bits  = mem_r[head_r];
`endif
  end

  // A bypassed packet never touches storage; flush drops the incoming write
  // but a same-cycle delivery still happened.
  always_comb begin
    enq_fire_s = enq_valid && enq_ready;
    deq_fire_s = deq_valid && deq_ready;
    push_s     = enq_fire_s && !bypass_take_s && !flush;
    pop_s      = deq_fire_s && !bypass_take_s;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage, intentionally not reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[tail_r] <= enq_bits;
    end
  end

  assign count = count_r;

  bpd_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .starve    (starve)
  );

endmodule

// File: tb/tb_bpd_commit_update_queue.sv
module tb_bpd_commit_update_queue;
  import bpd_update_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 16;

  logic                    clock;
  logic                    reset;
  logic                    flush;
  logic                    enq_valid;
  logic                    enq_ready;
  logic [BPD_UPDATE_W-1:0] enq_bits;
  logic                    deq_valid;
  logic                    deq_ready;
  logic [BPD_UPDATE_W-1:0] deq_bits;
  logic [2:0]              count;
  logic                    starve;

  bpd_commit_update_queue #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
    .count(count), .starve(starve)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: packet queue plus blocked-run length
  logic [BPD_UPDATE_W-1:0] mq[$];
  int blk = 0;

  typedef struct {
    logic        f, ev, dr;
    logic [39:0] pc;
    logic        x_dv, x_er;
    int          x_cnt;
    logic [39:0] x_pc;
  } vec_t;

  task automatic chk(input string name, input logic [BPD_UPDATE_W-1:0] act,
                     input logic [BPD_UPDATE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BPD_UPDATE_W-1:0] rnd_bits();
    logic [415:0] t;
    for (int i = 0; i < 13; i++) t[i*32 +: 32] = $urandom;
    return t[BPD_UPDATE_W-1:0];
  endfunction

  function automatic logic [BPD_UPDATE_W-1:0] pkt(input logic [39:0] pc);
    bpd_update_t p;
    p    = rnd_bits();
    p.pc = pc;
    return p;
  endfunction

  // drive inputs (called #1 after a rising edge) and let them settle
  task automatic apply(input logic f, input logic ev, input logic dr,
                       input logic [BPD_UPDATE_W-1:0] b);
    flush = f; enq_valid = ev; deq_ready = dr; enq_bits = b;
    #1;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, "_deq_valid"}, BPD_UPDATE_W'(deq_valid), BPD_UPDATE_W'(sz != 0));
    chk({tag, "_enq_ready"}, BPD_UPDATE_W'(enq_ready), BPD_UPDATE_W'(sz != DEPTH));
    chk({tag, "_count"},     BPD_UPDATE_W'(count),     BPD_UPDATE_W'(sz));
    chk({tag, "_starve"},    BPD_UPDATE_W'(starve),    BPD_UPDATE_W'(blk >= LIMIT));
    if (sz != 0) chk({tag, "_deq_bits"}, deq_bits, mq[0]);
  endtask

  // advance one clock, updating the model from the current inputs
  task automatic tick();
    int  sz;
    logic dvm, erm;
    sz  = mq.size();
    dvm = (sz != 0);
    erm = (sz != DEPTH);
    if (dvm && deq_ready) void'(mq.pop_front());
    if (flush) mq.delete();
    else if (enq_valid && erm) mq.push_back(enq_bits);
    if (flush || !dvm || deq_ready) blk = 0;
    else blk++;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    mq.delete();
    blk = 0;
  endtask

  initial begin
    vec_t vt[14];
    bpd_update_t hp;
    reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_bits = '0;

    // ---------------- reset state
    do_reset();
    #1;
    chk("rst_deq_valid", BPD_UPDATE_W'(deq_valid), '0);
    chk("rst_enq_ready", BPD_UPDATE_W'(enq_ready), BPD_UPDATE_W'(1));
    chk("rst_count",     BPD_UPDATE_W'(count),     '0);
    chk("rst_starve",    BPD_UPDATE_W'(starve),    '0);

    // ---------------- table: single pass-through, fill to full, reject, drain
    //        f     ev    dr    pc               dv    er    cnt  exp pc
    vt[0]  = '{1'b0, 1'b1, 1'b1, 40'h80000000, 1'b0, 1'b1, 0, 40'h0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 40'h0,        1'b1, 1'b1, 1, 40'h80000000};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 40'h0,        1'b0, 1'b1, 0, 40'h0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 40'h100,      1'b0, 1'b1, 0, 40'h0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 40'h104,      1'b1, 1'b1, 1, 40'h100};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 40'h108,      1'b1, 1'b1, 2, 40'h100};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 40'h10c,      1'b1, 1'b1, 3, 40'h100};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 40'h110,      1'b1, 1'b0, 4, 40'h100};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 40'h0,        1'b1, 1'b0, 4, 40'h100};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 40'h0,        1'b1, 1'b0, 4, 40'h100};
    vt[10] = '{1'b0, 1'b0, 1'b1, 40'h0,        1'b1, 1'b1, 3, 40'h104};
    vt[11] = '{1'b0, 1'b0, 1'b1, 40'h0,        1'b1, 1'b1, 2, 40'h108};
    vt[12] = '{1'b0, 1'b0, 1'b1, 40'h0,        1'b1, 1'b1, 1, 40'h10c};
    vt[13] = '{1'b0, 1'b0, 1'b0, 40'h0,        1'b0, 1'b1, 0, 40'h0};
    for (int i = 0; i < 14; i++) begin
      apply(vt[i].f, vt[i].ev, vt[i].dr, pkt(vt[i].pc));
      chk($sformatf("tbl%0d_deq_valid", i), BPD_UPDATE_W'(deq_valid), BPD_UPDATE_W'(vt[i].x_dv));
      chk($sformatf("tbl%0d_enq_ready", i), BPD_UPDATE_W'(enq_ready), BPD_UPDATE_W'(vt[i].x_er));
      chk($sformatf("tbl%0d_count", i),     BPD_UPDATE_W'(count),     BPD_UPDATE_W'(vt[i].x_cnt));
      chk($sformatf("tbl%0d_starve", i),    BPD_UPDATE_W'(starve),    '0);
      if (vt[i].x_dv) begin
        hp = deq_bits;
        chk($sformatf("tbl%0d_pc", i), BPD_UPDATE_W'(hp.pc), BPD_UPDATE_W'(vt[i].x_pc));
      end
      tick();
    end

    // ---------------- full queue with enq and deq offered together
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b0, 1'b1, 1'b0, pkt(40'h200 + 40'(i)));
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b1, 1'b1, pkt(40'h300 + 40'(i)));
      check_model($sformatf("full%0d", i));
      // first cycle only drains (enq_ready low at full), then holds at DEPTH-1
      chk($sformatf("full%0d_count_const", i), BPD_UPDATE_W'(count),
          BPD_UPDATE_W'(i == 0 ? DEPTH : DEPTH - 1));
      tick();
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      apply(1'b0, 1'b0, 1'b1, '0);
      check_model($sformatf("fdrain%0d", i));
      tick();
    end

    // ---------------- starvation
    apply(1'b0, 1'b1, 1'b0, pkt(40'h400));
    tick();
    for (int i = 1; i <= LIMIT; i++) begin
      apply(1'b0, 1'b0, 1'b0, '0);
      chk($sformatf("stv_blk%0d", i), BPD_UPDATE_W'(starve), '0);
      check_model("stv");
      tick();
    end
    apply(1'b0, 1'b0, 1'b0, '0);
    chk("stv_assert", BPD_UPDATE_W'(starve), BPD_UPDATE_W'(1));
    tick();
    apply(1'b0, 1'b0, 1'b1, '0);
    chk("stv_hold", BPD_UPDATE_W'(starve), BPD_UPDATE_W'(1));
    tick();
    apply(1'b0, 1'b0, 1'b0, '0);
    chk("stv_release", BPD_UPDATE_W'(starve), '0);
    check_model("stv_after");

    // ---------------- flush with a same-cycle enq
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 1'b0, pkt(40'h500 + 40'(i)));
      tick();
    end
    apply(1'b1, 1'b1, 1'b0, pkt(40'hdead));
    chk("fl_pre_count", BPD_UPDATE_W'(count), BPD_UPDATE_W'(3));
    tick();
    apply(1'b0, 1'b0, 1'b1, '0);
    chk("fl_count",     BPD_UPDATE_W'(count),     '0);
    chk("fl_deq_valid", BPD_UPDATE_W'(deq_valid), '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fl_gone%0d", i), BPD_UPDATE_W'(deq_valid), '0);
    end

    // ---------------- randomized against the model
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0 || i > 380, rnd_bits());
      check_model("rnd");
      tick();
    end
    // long random stall burst to exercise starve on random data
    for (int i = 0; i < 30; i++) begin
      apply(1'b0, $urandom_range(0, 1) == 1, 1'b0, rnd_bits());
      check_model("rstall");
      tick();
    end

    // ---------------- asynchronous reset mid-drain
    apply(1'b1, 1'b0, 1'b0, '0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 1'b0, pkt(40'h600 + 40'(i)));
      tick();
    end
    apply(1'b0, 1'b0, 1'b1, '0);
    tick();
    apply(1'b0, 1'b0, 1'b0, '0);
    chk("ar_pre_count", BPD_UPDATE_W'(count), BPD_UPDATE_W'(2));
    #2;
    reset = 1'b1;
    #1;
    chk("ar_deq_valid", BPD_UPDATE_W'(deq_valid), '0);
    chk("ar_count",     BPD_UPDATE_W'(count),     '0);
    chk("ar_starve",    BPD_UPDATE_W'(starve),    '0);
    chk("ar_enq_ready", BPD_UPDATE_W'(enq_ready), BPD_UPDATE_W'(1));
    @(posedge clock);
    #1;
    reset = 1'b0;
    mq.delete();
    blk = 0;
    apply(1'b0, 1'b1, 1'b1, pkt(40'h700));
    check_model("ar_after");
    tick();
    apply(1'b0, 1'b0, 1'b1, '0);
    check_model("ar_after2");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
